// File: rtl/gpio_apb_arbiter_if.sv
// Bundle of the two requester ports and the APB master bus around gpio_apb_arbiter.
// The arbiter takes the slave view; requesters plus the GPIO APB slave take the master view.
interface gpio_apb_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_write;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_write;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              busy;

  modport slave (
    input  req0_valid, req0_addr, req0_write, req0_wdata,
    input  req1_valid, req1_addr, req1_write, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy,
    input  PRDATA, PREADY
  );

  modport master (
    output req0_valid, req0_addr, req0_write, req0_wdata,
    output req1_valid, req1_addr, req1_write, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin two-port arbiter onto one APB master; zero-wait transfer is grant->response in 3 cycles.
// Requests stall (no ready) while a transfer is in flight; ACCESS waits on PREADY up to TIMEOUT cycles.
module gpio_apb_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  gpio_apb_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     ptr_q;
  logic                     owner_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [1:0]               grant;
  logic                     done_ok;
  logic                     done_to;

  logic                     psel_q;
  logic                     penable_q;
  logic                     pwrite_q;
  logic [ADDR_W-1:0]        paddr_q;
  logic [DATA_W-1:0]        pwdata_q;
  logic                     busy_q;
  logic [1:0]               rsp_vld_q;
  logic [1:0]               rsp_err_q;
  logic [1:0][DATA_W-1:0]   rsp_rdata_q;

  always_comb begin
    state_d = state_q;
    grant   = 2'b00;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      IDLE: begin
        // A lone requester wins regardless of the pointer
        if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
          grant = 2'b01;
        end else if (bus.req1_valid) begin
          grant = 2'b10;
        end
        if (grant != 2'b00) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      busy_q      <= 1'b0;
      rsp_vld_q   <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      busy_q      <= (state_d != IDLE);
      rsp_vld_q   <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;

      if (grant != 2'b00) begin
        owner_q  <= grant[1];
        ptr_q    <= ~grant[1];
        paddr_q  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
        pwrite_q <= grant[1] ? bus.req1_write : bus.req0_write;
        pwdata_q <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
      end

      // Cleared in SETUP so the first ACCESS cycle sees 0; saturates instead of wrapping
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (done_ok) begin
        rsp_vld_q[owner_q]   <= 1'b1;
        rsp_rdata_q[owner_q] <= pwrite_q ? '0 : bus.PRDATA;
      end
      if (done_to) begin
        rsp_vld_q[owner_q] <= 1'b1;
        rsp_err_q[owner_q] <= 1'b1;
      end
    end
  end

  // Ready is the only combinational output; gated so reset forces it low at once
  assign bus.req0_ready = grant[0] & ~PRESET;
  assign bus.req1_ready = grant[1] & ~PRESET;

  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp0_err   = rsp_err_q[0];
  assign bus.rsp0_rdata = rsp_rdata_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp1_err   = rsp_err_q[1];
  assign bus.rsp1_rdata = rsp_rdata_q[1];

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.busy    = busy_q;

  a_one_grant : assert property (@(posedge PCLK) disable iff (PRESET) !(grant[0] && grant[1]));

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboarded bench for gpio_apb_arbiter: tasks drive one scenario each and check timing inline,
// a negedge monitor pops the expected response queue on every rsp pulse.
module tb_gpio_apb_arbiter;

  logic PCLK;
  logic PRESET;

  gpio_apb_arbiter_if #(.ADDR_W(4), .DATA_W(32)) b ();

  gpio_apb_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (b.slave)
  );

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (!PRESET && (b.rsp0_valid || b.rsp1_valid)) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL rsp_unexpected: got rsp0_valid=%0b rsp1_valid=%0b, expected no response", b.rsp0_valid, b.rsp1_valid);
      end else begin
        exp_t e;
        logic [31:0] got_rdata;
        logic        got_err;
        e = sb.pop_front();
        got_rdata = b.rsp1_valid ? b.rsp1_rdata : b.rsp0_rdata;
        got_err   = b.rsp1_valid ? b.rsp1_err   : b.rsp0_err;
        total_cnt++;
        if ({b.rsp1_valid, b.rsp0_valid} !== (e.port ? 2'b10 : 2'b01))
          $display("FAIL rsp_port: got %b, expected port %0d", {b.rsp1_valid, b.rsp0_valid}, e.port);
        else pass_cnt++;
        total_cnt++;
        if (got_rdata !== e.rdata) $display("FAIL rsp_rdata: got %h, expected %h", got_rdata, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (got_err !== e.err) $display("FAIL rsp_err: got %b, expected %b", got_err, e.err);
        else pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_reqs();
    b.req0_valid = 1'b0; b.req0_addr = '0; b.req0_write = 1'b0; b.req0_wdata = '0;
    b.req1_valid = 1'b0; b.req1_addr = '0; b.req1_write = 1'b0; b.req1_wdata = '0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    clear_reqs();
    b.req0_valid = 1'b1;
    b.req1_valid = 1'b1;
    b.PREADY = 1'b1;
    b.PRDATA = '0;
    #2;
    total_cnt++;
    if ({b.req0_ready, b.req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b, expected 00", {b.req0_ready, b.req1_ready});
    else pass_cnt++;
    step(); step();
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE, b.PWRITE, b.busy} !== 4'b0000)
      $display("FAIL reset_ctrl: got PSEL/PENABLE/PWRITE/busy=%b, expected 0000", {b.PSEL, b.PENABLE, b.PWRITE, b.busy});
    else pass_cnt++;
    total_cnt++;
    if ({b.PADDR, b.PWDATA} !== 36'h0) $display("FAIL reset_bus: got PADDR=%h PWDATA=%h, expected 0", b.PADDR, b.PWDATA);
    else pass_cnt++;
    total_cnt++;
    if ({b.rsp0_valid, b.rsp0_err, b.rsp0_rdata, b.rsp1_valid, b.rsp1_err, b.rsp1_rdata} !== 68'h0)
      $display("FAIL reset_rsp: got nonzero response outputs, expected all 0");
    else pass_cnt++;
    step();
    PRESET = 1'b0;
    clear_reqs();
  endtask

  // Zero-wait write from port 0
  task automatic test_write();
    exp_t e;
    step();
    b.req0_valid = 1'b1; b.req0_addr = 4'h3; b.req0_write = 1'b1; b.req0_wdata = 32'h0F0FF0F5;
    b.PREADY = 1'b1;
    #1;
    total_cnt++;
    if ({b.req1_ready, b.req0_ready} !== 2'b01) $display("FAIL write_grant: got %b, expected 01", {b.req1_ready, b.req0_ready});
    else pass_cnt++;
    e.port = 1'b0; e.rdata = '0; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_reqs();
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE, b.busy} !== 3'b101) $display("FAIL write_setup: got PSEL/PENABLE/busy=%b, expected 101", {b.PSEL, b.PENABLE, b.busy});
    else pass_cnt++;
    total_cnt++;
    if ({b.PADDR, b.PWRITE, b.PWDATA} !== {4'h3, 1'b1, 32'h0F0FF0F5})
      $display("FAIL write_bus: got PADDR=%h PWRITE=%b PWDATA=%h, expected 3/1/0f0ff0f5", b.PADDR, b.PWRITE, b.PWDATA);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE, b.rsp0_valid, b.rsp0_rdata} !== {3'b110, 32'h0})
      $display("FAIL write_access: got PSEL/PENABLE/rsp0_valid=%b rdata=%h, expected 110/0", {b.PSEL, b.PENABLE, b.rsp0_valid}, b.rsp0_rdata);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if ({b.rsp0_valid, b.PSEL, b.PENABLE, b.busy} !== 4'b1000)
      $display("FAIL write_rsp_time: got rsp0_valid/PSEL/PENABLE/busy=%b, expected 1000", {b.rsp0_valid, b.PSEL, b.PENABLE, b.busy});
    else pass_cnt++;
    total_cnt++;
    if ({b.PADDR, b.PWDATA} !== {4'h3, 32'h0F0FF0F5}) $display("FAIL idle_hold: got PADDR=%h PWDATA=%h, expected 3/0f0ff0f5", b.PADDR, b.PWDATA);
    else pass_cnt++;
  endtask

  // Port 1 read with two wait states
  task automatic test_read_wait();
    exp_t e;
    step();
    b.req1_valid = 1'b1; b.req1_addr = 4'h1; b.req1_write = 1'b0; b.req1_wdata = 32'h55AA55AA;
    b.PREADY = 1'b0;
    b.PRDATA = 32'hFFFFFFFF;
    #1;
    total_cnt++;
    if ({b.req1_ready, b.req0_ready} !== 2'b10) $display("FAIL read_grant: got %b, expected 10", {b.req1_ready, b.req0_ready});
    else pass_cnt++;
    e.port = 1'b1; e.rdata = 32'hFFFFFFFF; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_reqs();
    step();
    step();
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE, b.PADDR, b.PWRITE} !== {2'b11, 4'h1, 1'b0})
      $display("FAIL read_wait_hold: got PSEL/PENABLE=%b PADDR=%h PWRITE=%b, expected 11/1/0", {b.PSEL, b.PENABLE}, b.PADDR, b.PWRITE);
    else pass_cnt++;
    step();
    b.PREADY = 1'b1;
    #1;
    total_cnt++;
    if (b.rsp1_valid !== 1'b0) $display("FAIL read_early_rsp: got rsp1_valid=%b at T+4, expected 0", b.rsp1_valid);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if ({b.rsp1_valid, b.rsp1_rdata, b.PSEL} !== {1'b1, 32'hFFFFFFFF, 1'b0})
      $display("FAIL read_rsp_time: got rsp1_valid=%b rdata=%h PSEL=%b, expected 1/ffffffff/0", b.rsp1_valid, b.rsp1_rdata, b.PSEL);
    else pass_cnt++;
  endtask

  // Lone requester granted against the pointer; withdrawn request never granted
  task automatic test_single();
    exp_t e;
    step();
    b.req0_valid = 1'b1; b.req0_addr = 4'h2; b.req0_write = 1'b1; b.req0_wdata = 32'h11112222;
    b.PREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      total_cnt++;
      if ({b.req1_ready, b.req0_ready} !== ((t == 0 || t == 3) ? 2'b01 : 2'b00))
        $display("FAIL single_grant_t%0d: got %b, expected %b", t, {b.req1_ready, b.req0_ready}, (t == 0 || t == 3) ? 2'b01 : 2'b00);
      else pass_cnt++;
      if (t == 0 || t == 3) begin
        e.port = 1'b0; e.rdata = '0; e.err = 1'b0;
        sb.push_back(e);
      end
      step();
      if (t == 0) begin
        b.req1_valid = 1'b1; b.req1_addr = 4'hE; b.req1_write = 1'b1;
      end
      if (t == 1) b.req1_valid = 1'b0;
      if (t == 3) clear_reqs();
    end
    step();
    step();
    #1;
    total_cnt++;
    if ({b.req1_ready, b.busy, b.PADDR} !== {2'b00, 4'h2})
      $display("FAIL withdrawn_req: got ready1=%b busy=%b PADDR=%h, expected 0/0/2", b.req1_ready, b.busy, b.PADDR);
    else pass_cnt++;
  endtask

  // Both requesters continuously valid from reset
  task automatic test_round_robin();
    exp_t e;
    logic [1:0] exp_rdy;
    step();
    PRESET = 1'b1;
    #1;
    step();
    PRESET = 1'b0;
    b.PREADY = 1'b1;
    b.PRDATA = 32'h12345678;
    b.req0_valid = 1'b1; b.req0_addr = 4'h4; b.req0_write = 1'b1; b.req0_wdata = 32'hCAFE0000;
    b.req1_valid = 1'b1; b.req1_addr = 4'h5; b.req1_write = 1'b0; b.req1_wdata = 32'h0;
    for (int w = 0; w < 12; w++) begin
      #1;
      exp_rdy = (w % 3 != 0) ? 2'b00 : (((w / 3) % 2 == 0) ? 2'b01 : 2'b10);
      total_cnt++;
      if ({b.req1_ready, b.req0_ready} !== exp_rdy)
        $display("FAIL rr_window%0d: got ready1/0=%b, expected %b", w, {b.req1_ready, b.req0_ready}, exp_rdy);
      else pass_cnt++;
      if (b.req0_ready || b.req1_ready) begin
        e.port = b.req1_ready;
        e.rdata = b.req1_ready ? 32'h12345678 : 32'h0;
        e.err = 1'b0;
        sb.push_back(e);
      end
      step();
    end
    clear_reqs();
    step(); step(); step();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   acc;
    logic seen;
    step();
    b.req0_valid = 1'b1; b.req0_addr = 4'h6; b.req0_write = 1'b0;
    b.PREADY = 1'b0;
    b.PRDATA = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (b.req0_ready !== 1'b1) $display("FAIL to_grant: got ready0=%b, expected 1", b.req0_ready);
    else pass_cnt++;
    e.port = 1'b0; e.rdata = '0; e.err = 1'b1;
    sb.push_back(e);
    step();
    clear_reqs();
    acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      if (b.rsp0_valid) begin
        seen = 1'b1;
        break;
      end
      if (b.PENABLE) acc++;
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL to_rsp_seen: got no rsp0 pulse within 20 cycles, expected one");
    else pass_cnt++;
    total_cnt++;
    if (acc != 4) $display("FAIL to_access_cycles: got %0d, expected 4", acc);
    else pass_cnt++;
    total_cnt++;
    if ({b.rsp0_err, b.rsp0_rdata, b.PSEL, b.PENABLE} !== {1'b1, 32'h0, 2'b00})
      $display("FAIL to_rsp: got err=%b rdata=%h PSEL/PENABLE=%b, expected 1/0/00", b.rsp0_err, b.rsp0_rdata, {b.PSEL, b.PENABLE});
    else pass_cnt++;
    b.PREADY = 1'b1;
  endtask

  // Reset asserted mid-ACCESS, between clock edges
  task automatic test_reset_mid();
    exp_t e;
    logic any_rsp;
    step();
    b.req1_valid = 1'b1; b.req1_addr = 4'h7; b.req1_write = 1'b1; b.req1_wdata = 32'hA5A5A5A5;
    b.PREADY = 1'b0;
    e.port = 1'b1; e.rdata = '0; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_reqs();
    step();
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE} !== 2'b11) $display("FAIL rm_in_access: got PSEL/PENABLE=%b, expected 11", {b.PSEL, b.PENABLE});
    else pass_cnt++;
    sb.delete();
    PRESET = 1'b1;
    #1;
    total_cnt++;
    if ({b.PSEL, b.PENABLE, b.busy} !== 3'b000) $display("FAIL rm_async: got PSEL/PENABLE/busy=%b, expected 000", {b.PSEL, b.PENABLE, b.busy});
    else pass_cnt++;
    step();
    step();
    PRESET = 1'b0;
    b.PREADY = 1'b1;
    any_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      any_rsp = any_rsp | b.rsp0_valid | b.rsp1_valid;
      step();
    end
    total_cnt++;
    if (any_rsp !== 1'b0) $display("FAIL rm_no_rsp: got a response pulse after release, expected none");
    else pass_cnt++;
    b.PRDATA = 32'h0BADF00D;
    b.req0_valid = 1'b1; b.req0_addr = 4'h8; b.req0_write = 1'b0;
    b.req1_valid = 1'b1; b.req1_addr = 4'h9; b.req1_write = 1'b0;
    #1;
    total_cnt++;
    if ({b.req1_ready, b.req0_ready} !== 2'b01) $display("FAIL rm_ptr_reset: got ready1/0=%b, expected 01", {b.req1_ready, b.req0_ready});
    else pass_cnt++;
    e.port = 1'b0; e.rdata = 32'h0BADF00D; e.err = 1'b0;
    sb.push_back(e);
    step();
    clear_reqs();
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    step(); step();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d outstanding responses, expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
